image_io_controller: RTL
========================

// Module: image_io_controller
// PURPOSE
// Host-side counterpart of the processor's segmented data memory: streams an input image
// into the pixel-in segment and raises startIO for the processor. It then waits for the
// processor's done flag and streams the pixel-out segment back to the host.
// Sits between the external host link and the I/O-side write/read port of the memory.
// PARAMETERS
// WIDTH     24      data/address width, matches memory word
// N_PIXELS  90000   pixels per image (300x300)
// IN_BASE   302     first address of pixel-in segment
// OUT_BASE  90302   first address of pixel-out segment
// PORTS
// clk        in   1      system clock
// rst        in   1      synchronous active-high reset
// go         in   1      1-cycle pulse: begin a load/process/drain transaction
// in_valid   in   1      host pixel valid
// in_ready   out  1      controller accepts pixel
// in_data    in   WIDTH  host pixel (low 8 bits significant, upper bits passed through)
// mem_we     out  1      write enable to memory
// mem_addr   out  WIDTH  absolute memory address
// mem_wd     out  WIDTH  write data
// mem_rd     in   WIDTH  read data, valid 1 cycle after mem_addr (registered read)
// start_io   out  1      drives memory startIO; processor polls it
// proc_done  in   1      level from processor: output image complete
// out_valid  out  1      pixel to host valid
// out_ready  in   1      host accepts pixel
// out_data   out  WIDTH  pixel to host
// busy       out  1      transaction in progress
// BEHAVIOUR
// - Reset: state=IDLE; idx=0; mem_we=0; mem_addr=0; mem_wd=0; start_io=0; in_ready=0;
//   out_valid=0; out_data=0; busy=0. Reset mid-transaction aborts immediately and writes nothing after it.
// - FSM: IDLE -go-> LOAD -idx==N_PIXELS-1 written-> START -> WAIT_DONE -proc_done-> DRAIN
//   -last pixel accepted by host-> IDLE. A go pulse outside IDLE is ignored.
// - LOAD: in_ready=1. Each in_valid&in_ready cycle, the same cycle drives mem_we=1,
//   mem_addr=IN_BASE+idx, mem_wd=in_data. idx increments, so throughput is one pixel per clock.
//   No write occurs without a handshake.
// - START: start_io=1 from this state until DRAIN completes; 0 again in IDLE.
// - WAIT_DONE: memory idle (mem_we=0). proc_done sampled in this state only.
//   A proc_done already high on entry is accepted the next cycle.
// - DRAIN: issue mem_addr=OUT_BASE+idx and capture mem_rd one cycle later into a 2-entry skid buffer.
//   out_data holds stable while out_valid&!out_ready. Reads stall when the buffer is full, so no
//   pixel is lost or duplicated. Back-to-back out_ready gives 1 pixel/clk after 1-cycle initial latency.
// - idx: 17-bit counter, cleared on every state entry, never wraps past N_PIXELS-1.
// - Address arithmetic is WIDTH-bit unsigned. IN_BASE+N_PIXELS-1 and OUT_BASE+N_PIXELS-1
//   stay below the startIO address (180302), so the controller never writes 0..301 (sine ROM)
//   or the startIO word.
// - busy=1 in every state except IDLE.
// STRUCTURE
// - Shared package io_pkg: state enum io_state_t {IDLE,LOAD,START,WAIT_DONE,DRAIN}.
//   It also holds the segment constants SIN_BASE=0, IN_BASE=302, OUT_BASE=90302,
//   STARTIO_ADDR=180302, N_PIXELS=90000, used by the memory top and by this block.
// - One sub-module: io_skid_buffer (2-entry valid/ready buffer, WIDTH data) for the DRAIN path.
// TESTING
// - Reset then go; feed 90000 pixels data=idx -> writes at addr 302..90301 with wd=idx,
//   start_io rises the cycle after the last write.
// - in_valid toggled 1/0 every cycle during LOAD -> exactly 90000 writes, no gaps in addresses.
// - Model returns mem_rd=addr-90302; assert proc_done; out_ready=1 -> out_data 0..89999 in order,
//   busy drops after the last pixel.
// - out_ready random 50% during DRAIN -> sequence still 0..89999, no drops or repeats,
//   out_data stable while stalled.
// - rst at pixel 500 of LOAD -> mem_we=0 next cycle, all outputs at reset values;
//   a new go restarts at addr 302.
// - go pulsed during WAIT_DONE -> ignored; proc_done high at entry -> DRAIN after one cycle.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the segmented data memory and its host-side I/O controller.
// Segment map: sine ROM, pixel-in, pixel-out, then the startIO word.
package io_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_DONE,
        DRAIN
    } io_state_t;

    localparam int unsigned SIN_BASE     = 0;
    localparam int unsigned IN_BASE      = 302;
    localparam int unsigned OUT_BASE     = 90302;
    localparam int unsigned STARTIO_ADDR = 180302;
    localparam int unsigned N_PIXELS     = 90000;

endpackage

// File: rtl/io_skid_buffer.sv
// Two-entry valid/ready buffer on the drain path; the head register holds out_data
// steady while the host stalls.
module io_skid_buffer #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [1:0]       level_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic [1:0][WIDTH-1:0] data_q;
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            level_q;
    logic                  push;
    logic                  pop;

    // The producer reserves space before issuing a read, so a full buffer never sees a push.
    assign push        = push_i && (level_q != 2'd2);
    assign pop         = out_valid_o && out_ready_i;
    assign out_valid_o = (level_q != 2'd0);
    assign out_data_o  = data_q[rd_ptr_q];
    assign level_o     = level_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            level_q  <= 2'd0;
        end else begin
            if (push) begin
                data_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            level_q <= level_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/image_io_controller.sv
// Host-side image loader/drainer: fills the pixel-in segment, raises startIO, waits for
// the processor's done flag, then streams the pixel-out segment back to the host.
module image_io_controller #(
    parameter int unsigned WIDTH    = 24,
    parameter int unsigned N_PIXELS = 90000,
    parameter int unsigned IN_BASE  = 302,
    parameter int unsigned OUT_BASE = 90302
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             go_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             mem_we_o,
    output logic [WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0] mem_wd_o,
    input  logic [WIDTH-1:0] mem_rd_i,
    output logic             start_io_o,
    input  logic             proc_done_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             busy_o
);

    import io_pkg::*;

    localparam int unsigned IDX_W = (N_PIXELS > 2) ? $clog2(N_PIXELS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_PIXELS - 1);

    io_state_t        state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] out_idx_q;
    logic             rd_all_q;
    logic             pend_q;
    logic             in_ready_q;
    logic             start_io_q;
    logic             busy_q;

    logic             wr_fire;
    logic             pop;
    logic             issue;
    logic [1:0]       sb_level;
    logic             sb_valid;

    // Reset gates the write strobe combinationally so the reset cycle itself writes nothing.
    assign wr_fire = (state_q == LOAD) && in_valid_i && in_ready_q && !rst_i;
    assign pop     = sb_valid && out_ready_i;
    // A read is issued only if buffered + in-flight pixels still fit after this cycle's pop.
    assign issue   = (state_q == DRAIN) && !rd_all_q &&
                     (({1'b0, sb_level} + {2'b0, pend_q}) < (3'd2 + {2'b0, pop}));

    always_comb begin
        mem_addr_o = '0;
        mem_wd_o   = '0;
        case (state_q)
            LOAD: begin
                mem_addr_o = WIDTH'(IN_BASE) + WIDTH'(idx_q);
                mem_wd_o   = in_data_i;
            end
            DRAIN:   mem_addr_o = WIDTH'(OUT_BASE) + WIDTH'(idx_q);
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            out_idx_q  <= '0;
            rd_all_q   <= 1'b0;
            pend_q     <= 1'b0;
            in_ready_q <= 1'b0;
            start_io_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            pend_q <= issue;
            case (state_q)
                IDLE: if (go_i) begin
                    state_q    <= LOAD;
                    idx_q      <= '0;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b1;
                end
                LOAD: if (wr_fire) begin
                    if (idx_q == LAST) begin
                        state_q    <= START;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        start_io_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                START: begin
                    state_q <= WAIT_DONE;
                    idx_q   <= '0;
                end
                WAIT_DONE: if (proc_done_i) begin
                    state_q   <= DRAIN;
                    idx_q     <= '0;
                    out_idx_q <= '0;
                    rd_all_q  <= 1'b0;
                end
                DRAIN: begin
                    if (issue) begin
                        if (idx_q == LAST) rd_all_q <= 1'b1;
                        else               idx_q    <= idx_q + 1'b1;
                    end
                    if (pop) begin
                        if (out_idx_q == LAST) begin
                            state_q    <= IDLE;
                            idx_q      <= '0;
                            out_idx_q  <= '0;
                            rd_all_q   <= 1'b0;
                            start_io_q <= 1'b0;
                            busy_q     <= 1'b0;
                        end else begin
                            out_idx_q <= out_idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    io_skid_buffer #(.WIDTH(WIDTH)) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (pend_q),
        .push_data_i (mem_rd_i),
        .level_o     (sb_level),
        .out_valid_o (sb_valid),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o)
    );

    assign mem_we_o    = wr_fire;
    assign in_ready_o  = in_ready_q;
    assign start_io_o  = start_io_q;
    assign out_valid_o = sb_valid;
    assign busy_o      = busy_q;

endmodule
